// File: rtl/config_pkg.sv
// Shared constants, header field positions and FSM encoding for the configuration frame writer.
package config_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam logic [3:0] OP_WRITE  = 4'hA;
    localparam logic [3:0] OP_DESYNC = 4'hD;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 28;
    localparam int PARITY_BIT = 27;
    localparam int IDX_MSB    = 7;
    localparam int IDX_LSB    = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        DATA   = 3'd2,
        SKIP   = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5
    } state_e;

    // States in which the writer consumes stream words.
    function automatic logic accepts_words(input state_e s);
        return (s == IDLE) || (s == HDR) || (s == DATA) || (s == SKIP);
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Frame index plus enable to one-hot strobe vector; purely combinational, registered by the parent.
module frame_strobe_decoder #(
    parameter int MaxFramesPerCol = 20
) (
    input  logic [7:0]                 index_i,
    input  logic                       enable_i,
    output logic [MaxFramesPerCol-1:0] strobe_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        strobe_o = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (enable_i && (index_i == 8'(i))) begin
                strobe_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_frame_writer.sv
// Sync-locked configuration stream decoder driving FrameData and a one-hot FrameStrobe pulse.
// Optional header parity check enabled by defining CONFIG_PARITY_EN.
module config_frame_writer
    import config_pkg::*;
#(
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter int          StrobeCycles    = 2,
    parameter logic [31:0] SyncWord        = SYNC_WORD
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [31:0]                WriteData,
    input  logic                       WriteValid,
    output logic                       WriteReady,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       Error
);

    localparam int               CNT_W    = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(StrobeCycles - 1);

    state_e                     state_q, state_d;
    logic [7:0]                 idx_q, idx_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       error_q, error_d;
`ifdef CONFIG_PARITY_EN
    logic                       parity_q, parity_d;
`endif

    logic       accept;
    logic       strobe_en;
    logic [3:0] hdr_op;
    logic [7:0] hdr_idx;
    logic       idx_ok;

    assign hdr_op  = WriteData[OP_MSB:OP_LSB];
    assign hdr_idx = WriteData[IDX_MSB:IDX_LSB];
    assign idx_ok  = ({24'd0, hdr_idx} < 32'(MaxFramesPerCol));

    // FSM state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
        end
    end

    // FSM next-state and datapath next values
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        error_d  = error_q;
`ifdef CONFIG_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept && (WriteData == SyncWord)) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    if (WriteData == SyncWord) begin
                        state_d = HDR;
                    end else if (hdr_op == OP_DESYNC) begin
                        state_d = IDLE;
                    end else if (hdr_op == OP_WRITE) begin
                        if (idx_ok) begin
                            idx_d    = hdr_idx;
`ifdef CONFIG_PARITY_EN
                            parity_d = WriteData[PARITY_BIT];
`endif
                            state_d  = DATA;
                        end else begin
                            error_d = 1'b1;
                            state_d = SKIP;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    data_d = WriteData[FrameBitsPerRow-1:0];
                    cnt_d  = '0;
`ifdef CONFIG_PARITY_EN
                    // A parity mismatch still loads the data but never strobes it into a latch.
                    if ((^WriteData) != parity_q) begin
                        error_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = STROBE;
                    end
`else
                    state_d = STROBE;
`endif
                end
            end
            SKIP: begin
                if (accept) begin
                    state_d = HDR;
                end
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                state_d = HDR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        WriteReady = accepts_words(state_q) && !reset;
        Busy       = (state_q != IDLE);
        accept     = WriteValid && WriteReady;
    end

    // Strobe is registered from the next state so it is high exactly while the state is STROBE.
    assign strobe_en = (state_d == STROBE);

    frame_strobe_decoder #(
        .MaxFramesPerCol(MaxFramesPerCol)
    ) u_decoder (
        .index_i (idx_q),
        .enable_i(strobe_en),
        .strobe_o(strobe_d)
    );

    always_ff @(posedge CLK or posedge reset) begin
        // NOTE: every register here is a small flop with a real reset value; there is no memory array to leave unreset.
        if (reset) begin
            idx_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

`ifdef CONFIG_PARITY_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign Error       = error_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer: expected strobe cycles are queued, a monitor pops and compares.
module tb_config_frame_writer;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    typedef struct packed {
        logic [19:0] strobe;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] WriteData = '0;
    logic        WriteValid = 1'b0;
    logic        WriteReady;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        Busy;
    logic        Error;

    int   passed = 0;
    int   total  = 0;
    exp_t exp_q[$];

    config_frame_writer dut (
        .CLK        (CLK),
        .reset      (reset),
        .WriteData  (WriteData),
        .WriteValid (WriteValid),
        .WriteReady (WriteReady),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Busy       (Busy),
        .Error      (Error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_strobe(input logic [19:0] s, input logic [31:0] d, input int cycles);
        exp_t e;
        e.strobe = s;
        e.data   = d;
        for (int i = 0; i < cycles; i++) exp_q.push_back(e);
    endtask

    // Presents a word from a falling edge and returns on the rising edge that accepts it.
    task automatic send(input logic [31:0] w, output int stalls);
        int n;
        n = 0;
        stalls = 0;
        @(negedge CLK);
        WriteData  = w;
        WriteValid = 1'b1;
        while (!WriteReady && n < 50) begin
            stalls++;
            n++;
            @(negedge CLK);
        end
        if (n >= 50) check("accept_timeout", WriteReady, 1);
        @(posedge CLK);
    endtask

    task automatic put(input logic [31:0] w);
        int s;
        send(w, s);
    endtask

    task automatic drop();
        @(negedge CLK);
        WriteValid = 1'b0;
    endtask

    // Monitor: every cycle with a strobe must match the head of the expected queue.
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", FrameStrobe, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe", FrameStrobe, e.strobe);
                check("strobe_data", FrameData, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rdy_exp[4] = '{0, 0, 0, 1};
        int s0, s1, s;
        logic exp_err;

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_data", FrameData, 0);
        check("rst_strobe", FrameStrobe, 0);
        check("rst_ready", WriteReady, 0);
        check("rst_busy", Busy, 0);
        check("rst_error", Error, 0);
        reset = 1'b0;

        // Words before sync are dropped
        put(32'h1234_5678);
        drop();
        check("presync_busy", Busy, 0);
        put(SYNC);
        drop();
        check("sync_busy", Busy, 1);
        check("sync_strobe", FrameStrobe, 0);

        // Basic write to frame 5
        expect_strobe(20'h00020, 32'hDEAD_BEEF, 2);
        put(32'hA000_0005);
        put(32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                WriteValid = 1'b0;
                check("write_data", FrameData, 32'hDEAD_BEEF);
            end
            check("write_ready", WriteReady, rdy_exp[i]);
            if (i == 2) begin
                check("hold_strobe", FrameStrobe, 0);
                check("hold_data", FrameData, 32'hDEAD_BEEF);
            end
        end
        check("no_error_yet", Error, 0);

        // Out-of-range index: error, one word skipped, resync word tolerated, next write works
        put(32'hA000_0014);
        drop();
        check("range_error", Error, 1);
        put(32'h5555_5555);
        drop();
        check("skip_data", FrameData, 32'hDEAD_BEEF);
        put(SYNC);
        expect_strobe(20'h00008, 32'h0000_0001, 2);
        put(32'hA800_0003);
        put(32'h0000_0001);
        drop();
        repeat (3) @(negedge CLK);
        check("after_skip_data", FrameData, 32'h0000_0001);
        check("after_skip_ready", WriteReady, 1);

        // Back-to-back frames 0 and 19 with WriteValid held high
        expect_strobe(20'h00001, 32'h0F0F_0F0F, 2);
        expect_strobe(20'h80000, 32'h8000_0000, 2);
        send(32'hA000_0000, s);
        send(32'h0F0F_0F0F, s);
        send(32'hA800_0013, s0);
        check("b2b_stall0", s0, 3);
        send(32'h8000_0000, s);
        send(32'hD000_0000, s1);
        check("b2b_stall1", s1, 3);
        drop();
        check("desync_busy", Busy, 0);

        // Reset during the second strobe cycle
        put(SYNC);
        expect_strobe(20'h00080, 32'h0000_0003, 1);
        put(32'hA000_0007);
        put(32'h0000_0003);
        drop();
        @(posedge CLK);
        #1 reset = 1'b1;
        #1;
        check("midrst_strobe", FrameStrobe, 0);
        check("midrst_data", FrameData, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_error", Error, 0);
        @(negedge CLK);
        reset = 1'b0;
        put(32'hA000_0002);
        put(32'h0000_0000);
        drop();
        repeat (3) @(negedge CLK);
        check("nosync_busy", Busy, 0);
        check("nosync_data", FrameData, 0);

        // Header with a wrong parity bit
        put(SYNC);
`ifdef CONFIG_PARITY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
        expect_strobe(20'h00010, 32'hDEAD_BEEF, 2);
`endif
        put(32'hA800_0004);
        put(32'hDEAD_BEEF);
        drop();
        repeat (3) @(negedge CLK);
        check("parity_data", FrameData, 32'hDEAD_BEEF);
        check("parity_error", Error, exp_err);
        check("parity_ready", WriteReady, 1);

        repeat (3) @(negedge CLK);
        check("pending_strobes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
